qmca_evt_buffer: RTL and testbench

Sample buffer between the ADC sample stream and the readout path of the QMCA acquisition state machine. It keeps a circular pre-trigger history and reports `buf_full` once that history is filled. While `sm_collect` is high it captures a fixed-length event window (pre-trigger plus post-trigger samples) and raises `evt_full`. While `sm_data` is high it drains the window on a valid/ready stream and raises `evt_empty` when the window has been read out.

---
 rtl/qmca_evt_buffer.sv | 173 +++++++++++++++++
 tb/tb_qmca_evt_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/qmca_evt_buffer.sv
// qmca_evt_buffer: pre-trigger ring, event window capture and valid/ready readout.
// Optional header word per event when QMCA_EVT_HEADER_EN is defined.
module qmca_evt_buffer #(
    parameter int DATA_WIDTH = 14,
    parameter int PRE_DEPTH  = 16,
    parameter int EVT_LEN    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    input  logic                  sm_collect,
    input  logic                  sm_data,
    input  logic [1:0]            sm_channel,
    output logic                  buf_full,
    output logic                  evt_full,
    output logic                  evt_empty,
    output logic                  pre_short,
    output logic [DATA_WIDTH+1:0] out_data,
    output logic                  out_hdr,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int AW = $clog2(EVT_LEN);
    localparam int FW = $clog2(PRE_DEPTH + 1);
    localparam int IW = AW + 2;
`ifdef QMCA_EVT_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic [DATA_WIDTH-1:0] mem [EVT_LEN];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [AW-1:0]         wr_ptr, start_ptr, rd_ptr;
    logic [FW-1:0]         fill_cnt;
    logic [AW:0]           word_cnt, cnt_base;
    logic [IW-1:0]         iss_idx, xfer_idx, total;
    logic [1:0]            channel;
    logic [DATA_WIDTH+1:0] sk_data, hdr_word, q_word;
    logic cap_d, pre_mode, cap_mode, rd_mode, cap_first, pre_we, cap_we, we;
    logic issue, pop, push, done, q_vld, q_hdr, sk_vld, sk_hdr;

`ifdef QMCA_EVT_HEADER_EN
    logic [15:0] evt_cnt;
    // event counter advances as each event finishes draining
    always_ff @(posedge clk or negedge rst)
        if (!rst) evt_cnt <= '0;
        else if (done) evt_cnt <= evt_cnt + 1'b1;
    assign hdr_word = {channel, evt_cnt[DATA_WIDTH-1:0]};
`else
    assign hdr_word = '0;
`endif

    // mode decode, write enables, readout issue and handshake control
    always_comb begin
        rd_mode   = sm_data;
        cap_mode  = sm_collect & ~sm_data;
        pre_mode  = ~sm_collect & ~sm_data;
        cap_first = cap_mode & ~cap_d & evt_empty;
        cnt_base  = cap_first ? (AW+1)'(fill_cnt) : word_cnt;
        pre_we    = pre_mode & adc_valid & evt_empty;
        cap_we    = cap_mode & adc_valid & evt_empty & (cnt_base != (AW+1)'(EVT_LEN));
        we        = pre_we | cap_we;
        total     = IW'(word_cnt) + IW'(HDR);
        rd_ptr    = start_ptr + AW'(iss_idx) - AW'(HDR);
        pop       = out_valid & out_ready;
        push      = q_vld & rd_mode;
        issue     = rd_mode & ~evt_empty & (iss_idx < total) &
                    (2'(out_valid) + 2'(sk_vld) + 2'(q_vld) < 2'(pop) + 2'd2);
        done      = pop & (xfer_idx == total - 1'b1);
        q_word    = q_hdr ? hdr_word : {channel, ram_q};
    end

    // sample RAM: one synchronous write port, one synchronous read port
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= adc_data;
        if (issue) ram_q <= mem[rd_ptr];
    end

    // pre-trigger fill, window capture and event status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_d     <= 1'b0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            word_cnt  <= '0;
            start_ptr <= '0;
            channel   <= '0;
            buf_full  <= 1'b0;
            evt_full  <= 1'b0;
            evt_empty <= 1'b1;
            pre_short <= 1'b0;
        end else begin
            cap_d <= cap_mode;
            if (we) wr_ptr <= wr_ptr + 1'b1;
            if (pre_we && fill_cnt != FW'(PRE_DEPTH)) fill_cnt <= fill_cnt + 1'b1;
            if (pre_we && fill_cnt == FW'(PRE_DEPTH - 1)) buf_full <= 1'b1;
            if (cap_first) begin
                start_ptr <= wr_ptr - AW'(fill_cnt);
                channel   <= sm_channel;
                pre_short <= fill_cnt < FW'(PRE_DEPTH);
            end
            if (cap_first || cap_we) word_cnt <= cnt_base + (AW+1)'(cap_we);
            if (cap_we && cnt_base == (AW+1)'(EVT_LEN - 1)) begin
                evt_full  <= 1'b1;
                evt_empty <= 1'b0;
            end
            if (rd_mode) evt_full <= 1'b0;
            if (done) begin
                evt_empty <= 1'b1;
                fill_cnt  <= '0;
                buf_full  <= 1'b0;
                pre_short <= 1'b0;
            end
        end
    end

    // read positions; issue position rewinds to just past the presented word when readout pauses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_idx  <= '0;
            xfer_idx <= '0;
        end else if (cap_first || done) begin
            iss_idx  <= '0;
            xfer_idx <= '0;
        end else begin
            if (pop) xfer_idx <= xfer_idx + 1'b1;
            iss_idx <= rd_mode ? iss_idx + IW'(issue) : xfer_idx + IW'(out_valid);
        end
    end

    // output register plus one-entry prefetch keeps full throughput under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_vld     <= 1'b0;
            q_hdr     <= 1'b0;
            sk_vld    <= 1'b0;
            sk_hdr    <= 1'b0;
            sk_data   <= '0;
            out_valid <= 1'b0;
            out_hdr   <= 1'b0;
            out_data  <= '0;
        end else begin
            q_vld <= issue;
            q_hdr <= issue & (HDR != 0) & (iss_idx == '0);
            if (pop) begin
                if (sk_vld && rd_mode) begin
                    out_data <= sk_data;
                    out_hdr  <= sk_hdr;
                end else if (push) begin
                    out_data <= q_word;
                    out_hdr  <= q_hdr;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (push && !out_valid) begin
                out_data  <= q_word;
                out_hdr   <= q_hdr;
                out_valid <= 1'b1;
            end
            if (!rd_mode) begin
                sk_vld <= 1'b0;
            end else if (push && (pop ? sk_vld : out_valid)) begin
                sk_data <= q_word;
                sk_hdr  <= q_hdr;
                sk_vld  <= 1'b1;
            end else if (pop) begin
                sk_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_qmca_evt_buffer.sv
// tb_qmca_evt_buffer: directed bench for qmca_evt_buffer (header checks follow QMCA_EVT_HEADER_EN).
module tb_qmca_evt_buffer;
    localparam int DW = 14;
`ifdef QMCA_EVT_HEADER_EN
    localparam int HDR_TB = 1;
`else
    localparam int HDR_TB = 0;
`endif

    logic          clk, rst;
    logic [DW-1:0] adc_data;
    logic          adc_valid, sm_collect, sm_data, out_ready;
    logic [1:0]    sm_channel;
    logic          buf_full, evt_full, evt_empty, pre_short, out_hdr, out_valid;
    logic [DW+1:0] out_data;
    int n_run = 0;
    int n_fail = 0;
    int ev_done = 0;

    qmca_evt_buffer dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .sm_collect(sm_collect), .sm_data(sm_data), .sm_channel(sm_channel),
        .buf_full(buf_full), .evt_full(evt_full), .evt_empty(evt_empty),
        .pre_short(pre_short), .out_data(out_data), .out_hdr(out_hdr),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_buf_full"}, buf_full, 0);
        chk({tag, "_evt_full"}, evt_full, 0);
        chk({tag, "_evt_empty"}, evt_empty, 1);
        chk({tag, "_pre_short"}, pre_short, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_hdr"}, out_hdr, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    // kind 1: expect buf_full to rise on sample 16 of a fill from empty; kind 2: evt_full on the last sample
    task automatic feed(input int first, input int n, input bit col, input logic [1:0] ch, input int kind);
        for (int i = 0; i < n; i++) begin
            adc_data   = DW'(first + i);
            adc_valid  = 1'b1;
            sm_collect = col;
            sm_channel = ch;
            tick();
            if (kind == 1) begin
                chk("pre_buf_full", buf_full, (i >= 15) ? 1 : 0);
                chk("pre_evt_empty", evt_empty, 1);
            end
            if (kind == 2) begin
                chk("cap_evt_full", evt_full, (i == n - 1) ? 1 : 0);
                chk("cap_evt_empty", evt_empty, (i == n - 1) ? 0 : 1);
            end
        end
        adc_valid = 1'b0;
    endtask

    task automatic read_event(input int first, input int n, input logic [1:0] ch, input bit bp, input int stop_at);
        int got = 0;
        int c = 0;
        int tot = n + HDR_TB;
        int want;
        logic xfer, pv;
        logic [DW+1:0] prev, e;
        sm_collect = 1'b0;
        adc_valid  = 1'b0;
        sm_data    = 1'b1;
        out_ready  = 1'b1;
        tick();
        chk("rd_lat_e1", out_valid, 0);
        chk("rd_evt_full_clr", evt_full, 0);
        tick();
        chk("rd_lat_e2", out_valid, 1);
        while (got < tot && got < stop_at && c < 1000) begin
            out_ready = bp ? !((c % 4 == 1) || (c % 4 == 2)) : 1'b1;
            xfer = out_valid & out_ready;
            pv   = out_valid;
            prev = out_data;
            if (xfer) begin
                e = (HDR_TB != 0 && got == 0) ? {ch, DW'(ev_done)} : {ch, DW'(first + got - HDR_TB)};
                chk("rd_data", out_data, e);
                chk("rd_hdr", out_hdr, (HDR_TB != 0 && got == 0) ? 1 : 0);
            end
            tick();
            c++;
            if (xfer) begin
                got++;
                if (got == tot) begin
                    chk("rd_done_empty", evt_empty, 1);
                    chk("rd_done_valid", out_valid, 0);
                end else begin
                    chk("rd_mid_empty", evt_empty, 0);
                end
            end else if (pv) begin
                chk("rd_stall_data", out_data, prev);
                chk("rd_stall_valid", out_valid, 1);
            end
        end
        want = (stop_at < tot) ? stop_at : tot;
        chk("rd_count", got, want);
        if (got == tot) begin
            ev_done++;
            sm_data = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        adc_data = '0;
        adc_valid = 1'b0;
        sm_collect = 1'b0;
        sm_data = 1'b0;
        sm_channel = '0;
        out_ready = 1'b1;
        #12;
        chk_reset_outputs("rst");
        rst = 1'b1;
        tick();

        feed(0, 16, 1'b0, 2'd0, 1);
        feed(16, 84, 1'b0, 2'd0, 0);
        chk("pre2_buf_full", buf_full, 1);
        feed(100, 48, 1'b1, 2'd2, 2);
        chk("cap_pre_short", pre_short, 0);
        adc_data = DW'(148);
        adc_valid = 1'b1;
        tick();
        chk("gap_evt_full", evt_full, 1);
        read_event(84, 64, 2'd2, 1'b0, 1000);
        chk("post_buf_full", buf_full, 0);

        feed(200, 20, 1'b0, 2'd0, 0);
        chk("bp_buf_full", buf_full, 1);
        feed(220, 48, 1'b1, 2'd1, 2);
        read_event(204, 64, 2'd1, 1'b1, 1000);

        feed(300, 5, 1'b0, 2'd0, 0);
        chk("short_buf_full", buf_full, 0);
        feed(305, 59, 1'b1, 2'd3, 2);
        chk("short_pre_short", pre_short, 1);
        read_event(300, 64, 2'd3, 1'b0, 1000);
        chk("short_pre_short_clr", pre_short, 0);

        feed(400, 16, 1'b0, 2'd0, 0);
        feed(416, 48, 1'b1, 2'd0, 2);
        read_event(400, 64, 2'd0, 1'b0, 10);
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        sm_data = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        ev_done = 0;
        feed(0, 16, 1'b0, 2'd0, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
